// File: rtl/uart_axi_ctrl.sv
// AXI4-lite master for a UART-lite slave: polls STAT and moves bytes between
// one-entry tx/rx holding registers and the UART FIFOs, one transaction at a time.
module uart_axi_ctrl #(
  parameter int unsigned RESET_FIFOS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [3:0]  axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [3:0]  axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        err
);
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam logic [AW-1:0] ADDR_RX   = AW'(4'h0);
  localparam logic [AW-1:0] ADDR_TX   = AW'(4'h4);
  localparam logic [AW-1:0] ADDR_STAT = AW'(4'h8);
  localparam logic [AW-1:0] ADDR_CTRL = AW'(4'hC);

  typedef enum logic [1:0] {ST_INIT, ST_POLL, ST_RX_RD, ST_TX_WR} state_e;
  typedef enum logic [1:0] {PH_START, PH_REQ, PH_RESP} phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [AW-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            tx_full_q, tx_full_d, rx_full_q, rx_full_d;
  logic [BW-1:0]   tx_byte_q, tx_byte_d, rx_byte_q, rx_byte_d;
  logic            last_tx_q, last_tx_d;
  logic            err_q, err_d;
  logic            is_wr, rx_cand, tx_cand, aw_left, w_left;
  logic            unused_rdata;

  assign unused_rdata = ^axi_rdata[DW-1:BW];

  // Next-state, AXI channel sequencing and holding-register updates
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wdata_d   = wdata_q;
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    last_tx_d = last_tx_q;
    err_d     = err_q;
    is_wr     = (state_q == ST_INIT) || (state_q == ST_TX_WR);
    rx_cand   = axi_rdata[0] && !rx_full_q;
    tx_cand   = !axi_rdata[3] && tx_full_q;
    aw_left   = awvalid_q && !axi_awready;
    w_left    = wvalid_q && !axi_wready;

    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data;
    end
    if (rx_full_q && rx_ready) rx_full_d = 1'b0;

    case (phase_q)
      PH_START: begin
        phase_d = PH_REQ;
        if (is_wr) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = (state_q == ST_INIT) ? ADDR_CTRL : ADDR_TX;
          wdata_d   = (state_q == ST_INIT) ? DW'(32'h3) : {24'h0, tx_byte_q};
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = (state_q == ST_POLL) ? ADDR_STAT : ADDR_RX;
        end
      end
      PH_REQ: begin
        if (is_wr) begin
          awvalid_d = aw_left;
          wvalid_d  = w_left;
          if (!aw_left && !w_left) begin
            bready_d = 1'b1;
            phase_d  = PH_RESP;
          end
        end else if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          phase_d   = PH_RESP;
        end
      end
      PH_RESP: begin
        if (is_wr && axi_bvalid) begin
          bready_d = 1'b0;
          phase_d  = PH_START;
          state_d  = ST_POLL;
          if (axi_bresp != 2'b00) err_d = 1'b1;
          if (state_q == ST_TX_WR) tx_full_d = 1'b0;
        end else if (!is_wr && axi_rvalid) begin
          rready_d = 1'b0;
          phase_d  = PH_START;
          if (axi_rresp != 2'b00) err_d = 1'b1;
          if (state_q == ST_RX_RD) begin
            rx_full_d = 1'b1;
            rx_byte_d = axi_rdata[BW-1:0];
            state_d   = ST_POLL;
          end else if (rx_cand && (!tx_cand || last_tx_q)) begin
            state_d   = ST_RX_RD;
            last_tx_d = 1'b0;
          end else if (tx_cand) begin
            state_d   = ST_TX_WR;
            last_tx_d = 1'b1;
          end else begin
            state_d   = ST_POLL;
          end
        end
      end
      default: phase_d = PH_START;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if (RESET_FIFOS != 0) state_q <= ST_INIT;
      else                  state_q <= ST_POLL;
      phase_q   <= PH_START;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wdata_q   <= '0;
      tx_full_q <= 1'b0;
      tx_byte_q <= '0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      last_tx_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wdata_q   <= wdata_d;
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      last_tx_q <= last_tx_d;
      err_q     <= err_d;
    end
  end

  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = 4'hF;
  assign axi_bready  = bready_q;
  assign tx_ready    = !tx_full_q;
  assign rx_valid    = rx_full_q;
  assign rx_data     = rx_byte_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_axi_ctrl.sv
// Bench for uart_axi_ctrl: UART-lite slave model plus a transaction-level
// reference of the polling / arbitration rules.
module tb_uart_axi_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  axi_araddr, axi_awaddr, axi_wstrb;
  logic        axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
  logic        axi_arready = 1'b1, axi_awready = 1'b1, axi_wready = 1'b1;
  logic        axi_rvalid = 1'b0, axi_bvalid = 1'b0;
  logic [31:0] axi_rdata = '0, axi_wdata;
  logic [1:0]  axi_rresp = '0, axi_bresp = '0;
  logic [7:0]  tx_data = '0, rx_data;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, err;

  localparam logic [3:0] ADDR_RX = 4'h0, ADDR_TX = 4'h4, ADDR_STAT = 4'h8, ADDR_CTRL = 4'hC;

  always #5 clk = ~clk;

  uart_axi_ctrl #(.RESET_FIFOS(1)) dut (
    .clk(clk), .rstn(rstn),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err)
  );

  typedef struct packed { logic wr; logic [3:0] addr; logic [31:0] data; } txn_t;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  txn_t exp_q[$];
  int svc[$];
  int poll_cnt = 0, rx_rd_cnt = 0, tx_wr_cnt = 0, b_cnt = 0;
  logic m_rx_full = 1'b0, m_tx_full = 1'b0, m_tx_last = 1'b1, m_err = 1'b0;
  logic [7:0] m_rx_byte = '0, m_tx_byte = '0;
  logic [3:0] ar_addr_l = '0, aw_addr_l = '0;
  logic [31:0] w_data_l = '0;
  logic [7:0] stat_drv = '0, rxbyte_drv = '0;
  logic [1:0] stat_rresp = '0, bresp_drv = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] data);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    return t;
  endfunction

  // UART-lite slave: answers each R/B request in the cycle it is requested
  always @(negedge clk) begin
    if (!rstn) begin
      axi_rvalid = 1'b0; axi_bvalid = 1'b0; axi_rresp = '0; axi_bresp = '0;
    end else begin
      axi_bvalid = axi_bready;
      axi_bresp  = axi_bready ? bresp_drv : 2'b00;
      axi_rvalid = axi_rready;
      if (axi_rready) begin
        axi_rdata = (ar_addr_l == ADDR_STAT) ? {24'h0, stat_drv} : {24'($urandom), rxbyte_drv};
        axi_rresp = (ar_addr_l == ADDR_STAT) ? stat_rresp : 2'b00;
      end
    end
  end

  // Reference model: holding registers, sticky error, expected next transaction
  always @(posedge clk) begin : model
    txn_t e;
    logic rxf, txf, rx_c, tx_c;
    if (!rstn) begin
      m_rx_full = 1'b0; m_tx_full = 1'b0; m_tx_last = 1'b1; m_err = 1'b0;
      exp_q.delete();
      exp_q.push_back(mk(1'b1, ADDR_CTRL, 32'h3));
    end else begin
      rxf = m_rx_full;
      txf = m_tx_full;
      if (rx_ready && rxf) m_rx_full = 1'b0;
      if (tx_valid && !txf) begin m_tx_full = 1'b1; m_tx_byte = tx_data; end
      if (axi_arvalid && axi_arready) ar_addr_l = axi_araddr;
      if (axi_awvalid && axi_awready) aw_addr_l = axi_awaddr;
      if (axi_wvalid && axi_wready) begin
        w_data_l = axi_wdata;
        check("wstrb", 32'(axi_wstrb), 32'hF);
      end
      if (axi_rvalid && axi_rready) begin
        if (axi_rresp != 2'b00) m_err = 1'b1;
        check("one_outstanding_r", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rd_kind", 32'(1'b0), 32'(e.wr));
          check("rd_addr", 32'(ar_addr_l), 32'(e.addr));
          if (e.addr == ADDR_STAT) begin
            poll_cnt++;
            rx_c = axi_rdata[0] && !rxf;
            tx_c = !axi_rdata[3] && txf;
            if (rx_c && (!tx_c || m_tx_last)) begin
              exp_q.push_back(mk(1'b0, ADDR_RX, 32'h0)); m_tx_last = 1'b0;
            end else if (tx_c) begin
              exp_q.push_back(mk(1'b1, ADDR_TX, {24'h0, m_tx_byte})); m_tx_last = 1'b1;
            end else begin
              exp_q.push_back(mk(1'b0, ADDR_STAT, 32'h0));
            end
          end else begin
            m_rx_full = 1'b1;
            m_rx_byte = axi_rdata[7:0];
            rx_rd_cnt++;
            svc.push_back(0);
            exp_q.push_back(mk(1'b0, ADDR_STAT, 32'h0));
          end
        end
      end
      if (axi_bvalid && axi_bready) begin
        b_cnt++;
        if (axi_bresp != 2'b00) m_err = 1'b1;
        check("one_outstanding_b", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_kind", 32'(1'b1), 32'(e.wr));
          check("wr_addr", 32'(aw_addr_l), 32'(e.addr));
          check("wr_data", w_data_l, e.data);
          if (e.addr == ADDR_TX) begin
            m_tx_full = 1'b0;
            tx_wr_cnt++;
            svc.push_back(1);
          end
          exp_q.push_back(mk(1'b0, ADDR_STAT, 32'h0));
        end
      end
    end
  end

  // Stream-side outputs against the model every cycle
  always @(negedge clk) begin
    if (rstn) begin
      check("tx_ready", 32'(tx_ready), 32'(!m_tx_full));
      check("rx_valid", 32'(rx_valid), 32'(m_rx_full));
      if (m_rx_full) check("rx_data_stable", 32'(rx_data), 32'(m_rx_byte));
      check("err_sticky", 32'(err), 32'(m_err));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_arvalid", 32'(axi_arvalid), 32'd0);
    check("rst_awvalid", 32'(axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(axi_wvalid), 32'd0);
    check("rst_rready", 32'(axi_rready), 32'd0);
    check("rst_bready", 32'(axi_bready), 32'd0);
    check("rst_araddr", 32'(axi_araddr), 32'd0);
    check("rst_awaddr", 32'(axi_awaddr), 32'd0);
    check("rst_wdata", axi_wdata, 32'd0);
    check("rst_wstrb", 32'(axi_wstrb), 32'hF);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_polls(input int n, input string tag);
    int target;
    int cyc;
    target = poll_cnt + n;
    cyc = 0;
    while (poll_cnt < target && cyc < 2000) begin @(negedge clk); cyc++; end
    check({tag, "_poll_timeout"}, 32'(poll_cnt >= target), 32'd1);
  endtask

  initial begin : stim
    int base, cyc;
    do_reset();
    wait_polls(2, "init");

    // RX byte held until consumed; no further RX reads meanwhile
    stat_drv = 8'h01; rxbyte_drv = 8'h41; rx_ready = 1'b0;
    base = rx_rd_cnt;
    wait_polls(4, "rx_hold");
    check("rx_valid_41", 32'(rx_valid), 32'd1);
    check("rx_data_41", 32'(rx_data), 32'h41);
    check("rx_single_read", 32'(rx_rd_cnt - base), 32'd1);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    wait_polls(3, "rx_refill");
    check("rx_second_read", 32'(rx_rd_cnt - base), 32'd2);
    stat_drv = 8'h00; rx_ready = 1'b1;
    wait_polls(2, "rx_drain");
    rx_ready = 1'b0;

    // TX blocked by TX-full for 3 polls
    stat_drv = 8'h08;
    @(negedge clk); tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    base = tx_wr_cnt;
    wait_polls(3, "tx_full");
    check("tx_blocked", 32'(tx_wr_cnt - base), 32'd0);
    check("tx_ready_busy", 32'(tx_ready), 32'd0);
    stat_drv = 8'h00;
    cyc = 0;
    while (!axi_bready && cyc < 200) begin @(negedge clk); cyc++; end
    check("tx_b_seen", 32'(axi_bready), 32'd1);
    check("tx_ready_at_b", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("tx_ready_after_b", 32'(tx_ready), 32'd1);
    check("tx_wdata_55", w_data_l, 32'h55);
    check("tx_waddr", 32'(aw_addr_l), 32'(ADDR_TX));

    // Round-robin with both candidates pending
    stat_drv = 8'h01; rx_ready = 1'b1; tx_valid = 1'b1;
    base = svc.size();
    cyc = 0;
    while (svc.size() < base + 4 && cyc < 600) begin
      @(negedge clk); tx_data = 8'($urandom); cyc++;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order_%0d", i), 32'((svc.size() > base + i) ? svc[base + i] : 9), 32'(i % 2));
    tx_valid = 1'b0; stat_drv = 8'h00;
    wait_polls(3, "rr_drain");
    rx_ready = 1'b0;

    // AW accepted 3 cycles after W
    axi_awready = 1'b0;
    @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    base = b_cnt;
    cyc = 0;
    while (!axi_awvalid && cyc < 200) begin @(negedge clk); cyc++; end
    check("aw_seen", 32'(axi_awvalid), 32'd1);
    check("w_first", 32'(axi_wvalid), 32'd1);
    @(negedge clk);
    check("w_dropped", 32'(axi_wvalid), 32'd0);
    check("aw_held_1", 32'(axi_awvalid), 32'd1);
    @(negedge clk);
    check("aw_held_2", 32'(axi_awvalid), 32'd1);
    check("no_bready_yet", 32'(axi_bready), 32'd0);
    @(negedge clk);
    check("aw_held_3", 32'(axi_awvalid), 32'd1);
    axi_awready = 1'b1;
    @(negedge clk);
    check("aw_dropped", 32'(axi_awvalid), 32'd0);
    wait_polls(2, "aw_delay");
    check("single_b", 32'(b_cnt - base), 32'd1);

    // SLVERR on a STAT read, cleared only by reset
    stat_rresp = 2'b10;
    wait_polls(2, "rresp_err");
    stat_rresp = 2'b00;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    wait_polls(2, "err_hold");
    check("err_still_set", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    check("err_after_reset", 32'(err), 32'd0);
    wait_polls(2, "post_reset");

    // Randomized traffic, ready stalls and error responses
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      stat_drv    = 8'($urandom) & 8'h09;
      rxbyte_drv  = 8'($urandom);
      rx_ready    = ($urandom_range(0, 2) == 0);
      tx_valid    = ($urandom_range(0, 1) == 0);
      tx_data     = 8'($urandom);
      axi_arready = ($urandom_range(0, 3) != 0);
      axi_awready = ($urandom_range(0, 3) != 0);
      axi_wready  = ($urandom_range(0, 3) != 0);
      stat_rresp  = ($urandom_range(0, 59) == 0) ? 2'b01 : 2'b00;
      bresp_drv   = ($urandom_range(0, 29) == 0) ? 2'b10 : 2'b00;
    end
    @(negedge clk);
    axi_arready = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    stat_drv = 8'h00; stat_rresp = 2'b00; bresp_drv = 2'b00;
    tx_valid = 1'b0; rx_ready = 1'b1;
    wait_polls(4, "final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_axi_ctrl.md
UART_AXI_CTRL -- requirements
Module: uart_axi_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_FIFOS, default 1, meaning: when 1, write CTRL=0x3 after reset to clear both UART FIFOs before polling.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have AXI4-lite master ports axi_araddr/axi_awaddr (output, 4 bits), axi_arvalid/axi_awvalid/axi_wvalid/axi_rready/axi_bready (output, 1 bit), axi_arready/axi_awready/axi_wready/axi_rvalid/axi_bvalid (input, 1 bit), axi_wdata (output, 32 bits), axi_wstrb (output, 4 bits), axi_rdata (input, 32 bits), axi_rresp/axi_bresp (input, 2 bits); these connect to a UART-lite slave.
REQ-005 The block SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): the byte-send stream.
REQ-006 The block SHALL have ports rx_data (output, 8 bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): the byte-receive stream.
REQ-007 The block SHALL have port err, output, 1 bit: sticky flag set on any non-OKAY response.

Function
REQ-008 Register map SHALL be: RX FIFO 0x0, TX FIFO 0x4, STAT 0x8 (bit0 RX valid, bit3 TX full), CTRL 0xC.
REQ-009 The block SHALL implement states INIT, POLL, RX_RD, TX_WR; INIT is entered from reset when RESET_FIFOS=1, otherwise POLL is entered.
REQ-010 INIT SHALL write 0x00000003 to 0xC, then go to POLL on the B handshake.
REQ-011 A write SHALL assert awvalid and wvalid together in the cycle after state entry; each is held until its own ready is sampled high, and they may be accepted independently; bready SHALL then be held high until bvalid.
REQ-012 A read SHALL assert arvalid in the cycle after state entry, hold it until arready is sampled high, then hold rready high until rvalid.
REQ-013 axi_wstrb SHALL be 4'b1111 for every write; axi_wdata SHALL be {24'b0, byte} for TX writes.
REQ-014 POLL SHALL read 0x8 and capture axi_rdata on the R handshake.
REQ-015 After a POLL, the RX_RD candidate SHALL be (stat[0] and rx holding empty) and the TX_WR candidate SHALL be (!stat[3] and tx holding full).
REQ-016 If both candidates are true, the block SHALL choose the one not served last (round-robin flag; reset value = TX served last, so RX goes first); otherwise it SHALL take the single true candidate, or re-enter POLL if neither is true.
REQ-017 RX_RD SHALL read 0x0 and, on the R handshake, load rdata[7:0] into the rx holding register, set rx_valid and return to POLL.
REQ-018 TX_WR SHALL write the tx holding byte to 0x4 and, on the B handshake, empty the tx holding register and return to POLL.
REQ-019 The tx holding register SHALL be one entry with tx_ready = !full; a byte is captured when tx_valid && tx_ready.
REQ-020 The rx holding register SHALL be one entry with rx_valid = full; it is emptied when rx_valid && rx_ready.
REQ-021 tx_ready SHALL NOT rise in the same cycle as the B handshake that empties the tx holding register (it rises one cycle after).
REQ-022 rx_data SHALL remain stable while rx_valid=1.
REQ-023 err SHALL be set when rresp!=0 at an R handshake or bresp!=0 at a B handshake; the transaction SHALL still complete as if OKAY, and err is cleared only by reset.
REQ-024 The block SHALL never have more than one AXI transaction outstanding.

Reset
REQ-025 While rstn=0, all AXI valid/ready outputs, the address outputs, axi_wdata, rx_valid, rx_data and err SHALL be 0; axi_wstrb SHALL be 4'b1111 and tx_ready SHALL be 1.
REQ-026 While rstn=0, both holding registers SHALL be empty and the round-robin flag SHALL be TX-served-last.
REQ-027 Reset asserted mid-transaction SHALL drop all valids immediately; no transaction is resumed after reset.

Verification
REQ-028 Reset, RESET_FIFOS=1, slave always ready -> first transaction is a write of 0x3 to 0xC, followed by a read of 0x8.
REQ-029 STAT=0x01, RX data=0x41, rx_ready=0 -> rx_valid=1 with rx_data=0x41; subsequent polls do not read 0x0 until rx_ready pulses.
REQ-030 tx_data=0x55 sent, STAT=0x08 for 3 polls then 0x00 -> no write to 0x4 until STAT=0x00, then a write with wdata=0x00000055; tx_ready=1 in the cycle after bvalid.
REQ-031 STAT=0x01 with TX pending on consecutive polls -> the order of serviced transactions is RX, TX, RX, TX.
REQ-032 awready delayed 3 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid is held 4 cycles, and exactly one B handshake occurs.
REQ-033 rresp=2'b10 on a STAT read, then rstn pulsed low -> err=1 until reset, then err=0 and all valids=0.
